trigger_capture_ctrl: RTL and testbench

Capture sequencer that sits directly downstream of the trigger-arm FSM. It takes the `TriggerArmed` level and the ADC sample stream, and fills a circular sample buffer with a fixed pre-trigger history. It then detects a threshold crossing on the selected slope, records a fixed number of post-trigger samples, and reports the captured window to the readout logic. The window is held until readout acknowledges it.

---
 rtl/trigger_capture_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_trigger_capture_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture_ctrl.sv
// Pre/post-trigger capture sequencer feeding a circular sample buffer.
// Optional feature macro: TRIG_FORCE_EN adds a ForceTrig input that triggers unconditionally in WAIT_TRIG.
module trigger_capture_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int PRE_SAMPLES  = 256,
    parameter int POST_SAMPLES = 512
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  TriggerArmed,
    input  logic                  SampleValid,
    input  logic [DATA_WIDTH-1:0] Sample,
    input  logic [DATA_WIDTH-1:0] Threshold,
    input  logic                  TrigSlope,
    input  logic                  ReadDone,
`ifdef TRIG_FORCE_EN
    input  logic                  ForceTrig,
`endif
    output logic                  WrEn,
    output logic [ADDR_WIDTH-1:0] WrAddr,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [ADDR_WIDTH-1:0] TrigAddr,
    output logic [ADDR_WIDTH-1:0] StartAddr,
    output logic                  Busy,
    output logic                  CaptureDone
);

    localparam int PRE_W  = (PRE_SAMPLES  > 1) ? $clog2(PRE_SAMPLES)  : 1;
    localparam int POST_W = (POST_SAMPLES > 1) ? $clog2(POST_SAMPLES) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(PRE_SAMPLES - 1);
    localparam logic [POST_W-1:0]     POST_LAST = POST_W'(POST_SAMPLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PRE_OFFS  = ADDR_WIDTH'(PRE_SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptrNext;
    logic [PRE_W-1:0]      preCnt;
    logic [PRE_W-1:0]      preCntNext;
    logic [POST_W-1:0]     postCnt;
    logic [POST_W-1:0]     postCntNext;
    logic [DATA_WIDTH-1:0] prevSample;
    logic [DATA_WIDTH-1:0] prevSampleNext;
    logic                  prevValid;
    logic                  prevValidNext;
    logic                  accept;
    logic                  trigHit;
    logic                  risingHit;
    logic                  fallingHit;
    logic                  crossing;
    logic                  forceHit;

    // Threshold crossing against the previous valid sample, unsigned full width
    assign risingHit  = prevValid && (prevSample < Threshold) && (Sample >= Threshold);
    assign fallingHit = prevValid && (prevSample > Threshold) && (Sample <= Threshold);
    assign crossing   = TrigSlope ? risingHit : fallingHit;

`ifdef TRIG_FORCE_EN
    assign forceHit = ForceTrig;
`else
    assign forceHit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            preCnt     <= '0;
            postCnt    <= '0;
            prevSample <= '0;
            prevValid  <= 1'b0;
        end else begin
            state      <= stateNext;
            ptr        <= ptrNext;
            preCnt     <= preCntNext;
            postCnt    <= postCntNext;
            prevSample <= prevSampleNext;
            prevValid  <= prevValidNext;
        end
    end

    // Abort on a dropped arm level takes priority over accepting the sample in that cycle
    always_comb begin
        stateNext      = state;
        ptrNext        = ptr;
        preCntNext     = preCnt;
        postCntNext    = postCnt;
        prevSampleNext = prevSample;
        prevValidNext  = prevValid;
        accept         = 1'b0;
        trigHit        = 1'b0;
        case (state)
            IDLE: begin
                if (TriggerArmed) begin
                    stateNext     = PREFILL;
                    ptrNext       = '0;
                    preCntNext    = '0;
                    prevValidNext = 1'b0;
                end
            end
            PREFILL: begin
                if (!TriggerArmed) begin
                    stateNext = IDLE;
                end else if (SampleValid) begin
                    accept         = 1'b1;
                    ptrNext        = ptr + ADDR_WIDTH'(1);
                    prevSampleNext = Sample;
                    prevValidNext  = 1'b1;
                    if (preCnt == PRE_LAST) begin
                        stateNext = WAIT_TRIG;
                    end else begin
                        preCntNext = preCnt + PRE_W'(1);
                    end
                end
            end
            WAIT_TRIG: begin
                if (!TriggerArmed) begin
                    stateNext = IDLE;
                end else if (SampleValid) begin
                    accept         = 1'b1;
                    ptrNext        = ptr + ADDR_WIDTH'(1);
                    prevSampleNext = Sample;
                    prevValidNext  = 1'b1;
                    if (crossing || forceHit) begin
                        trigHit     = 1'b1;
                        stateNext   = POST;
                        postCntNext = '0;
                    end
                end
            end
            POST: begin
                if (SampleValid) begin
                    accept  = 1'b1;
                    ptrNext = ptr + ADDR_WIDTH'(1);
                    if (postCnt == POST_LAST) begin
                        stateNext = DONE;
                    end else begin
                        postCntNext = postCnt + POST_W'(1);
                    end
                end
            end
            DONE: begin
                if (ReadDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // CaptureDone waits one cycle in DONE so it follows the final write; Busy drops with it
    always_ff @(posedge Clock) begin
        if (Reset) begin
            WrEn        <= 1'b0;
            WrAddr      <= '0;
            WrData      <= '0;
            TrigAddr    <= '0;
            StartAddr   <= '0;
            Busy        <= 1'b0;
            CaptureDone <= 1'b0;
        end else begin
            WrEn <= accept;
            if (accept) begin
                WrAddr <= ptr;
                WrData <= Sample;
            end
            if (trigHit) begin
                TrigAddr  <= ptr;
                StartAddr <= ptr - PRE_OFFS;
            end
            Busy        <= (stateNext != IDLE) && (state != DONE);
            CaptureDone <= (state == DONE) && (stateNext == DONE);
        end
    end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed bench for trigger_capture_ctrl: vector table of capture scenarios plus hand-written corner sequences.
module tb_trigger_capture_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int PRE  = 4;
    localparam int POST = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          TriggerArmed;
    logic          SampleValid;
    logic [DW-1:0] Sample;
    logic [DW-1:0] Threshold;
    logic          TrigSlope;
    logic          ReadDone;
`ifdef TRIG_FORCE_EN
    logic          forceTrig;
`endif
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic [AW-1:0] TrigAddr;
    logic [AW-1:0] StartAddr;
    logic          Busy;
    logic          CaptureDone;

    trigger_capture_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PRE_SAMPLES (PRE),
        .POST_SAMPLES(POST)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .TriggerArmed(TriggerArmed),
        .SampleValid (SampleValid),
        .Sample      (Sample),
        .Threshold   (Threshold),
        .TrigSlope   (TrigSlope),
        .ReadDone    (ReadDone),
`ifdef TRIG_FORCE_EN
        .ForceTrig   (forceTrig),
`endif
        .WrEn        (WrEn),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
        .TrigAddr    (TrigAddr),
        .StartAddr   (StartAddr),
        .Busy        (Busy),
        .CaptureDone (CaptureDone)
    );

    always #5 Clock = ~Clock;

    int cycleCnt = 0;
    always @(posedge Clock) cycleCnt <= cycleCnt + 1;

    int totalChecks  = 0;
    int passedChecks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            edgeNum;
    } wr_t;

    wr_t           expQ[$];
    wr_t           monEntry;
    logic [AW-1:0] addrModel;

    typedef struct {
        string          name;
        logic           slope;
        int             nFill;
        logic [7:0]     fillVal;
        logic [5:0][7:0] seq;
        int             nSeq;
        int             gap;
        logic           expTrig;
        logic [AW-1:0]  expTrigAddr;
        logic [AW-1:0]  expStartAddr;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Every buffer write must match the next expected {edge, address, data}
    always @(negedge Clock) begin
        if (WrEn) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(WrEn), 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("writeEdgeAddrData",
                            {cycleCnt[15:0], 3'b000, WrAddr, WrData},
                            {monEntry.edgeNum[15:0], 3'b000, monEntry.addr, monEntry.data});
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset        = 1'b1;
        TriggerArmed = 1'b0;
        SampleValid  = 1'b0;
        ReadDone     = 1'b0;
`ifdef TRIG_FORCE_EN
        forceTrig    = 1'b0;
`endif
        tick();
        tick();
        Reset = 1'b0;
        expQ.delete();
        addrModel = '0;
    endtask

    task automatic armCapture();
        TriggerArmed = 1'b1;
        SampleValid  = 1'b1;
        Sample       = 8'h55;
        tick();
        addrModel = '0;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit expectWrite, input int gap);
        wr_t w;
        SampleValid = 1'b1;
        Sample      = data;
        if (expectWrite) begin
            w.addr    = addrModel;
            w.data    = data;
            w.edgeNum = cycleCnt + 1;
            expQ.push_back(w);
            addrModel = addrModel + 1'b1;
        end
        tick();
        if (gap > 0) begin
            SampleValid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic runPost(input logic [7:0] base, input bit dropArm);
        if (dropArm) TriggerArmed = 1'b0;
        for (int i = 0; i < POST; i++) applyStimulus(base + 8'(i), 1'b1, 0);
        SampleValid = 1'b0;
        @(negedge Clock);
        checkOutput("doneAtLastWrite", 32'(CaptureDone), 32'd0);
        checkOutput("busyAtLastWrite", 32'(Busy), 32'd1);
        @(negedge Clock);
        checkOutput("doneAfterLastWrite", 32'(CaptureDone), 32'd1);
        checkOutput("busyAfterLastWrite", 32'(Busy), 32'd0);
        TriggerArmed = 1'b0;
        @(negedge Clock);
        checkOutput("doneHeld", 32'(CaptureDone), 32'd1);
        ReadDone = 1'b1;
        tick();
        ReadDone = 1'b0;
        @(negedge Clock);
        checkOutput("doneAfterReadDone", {30'd0, CaptureDone, Busy}, 32'd0);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic runVector(input vec_t v);
        doReset();
        TrigSlope = v.slope;
        armCapture();
        for (int i = 0; i < v.nFill; i++) applyStimulus(v.fillVal, 1'b1, v.gap);
        for (int i = 0; i < v.nSeq; i++) applyStimulus(v.seq[i], 1'b1, v.gap);
        @(negedge Clock);
        checkOutput({v.name, ".trigAddr"}, 32'(TrigAddr), 32'(v.expTrigAddr));
        checkOutput({v.name, ".startAddr"}, 32'(StartAddr), 32'(v.expStartAddr));
        if (v.expTrig) begin
            runPost(8'h20, 1'b0);
        end else begin
            for (int i = 0; i < POST + 4; i++) applyStimulus(v.seq[v.nSeq-1], 1'b1, 0);
            SampleValid = 1'b0;
            @(negedge Clock);
            checkOutput({v.name, ".stillWaiting"}, {30'd0, Busy, CaptureDone}, 32'd2);
            checkOutput({v.name, ".trigAddrUntouched"}, 32'(TrigAddr), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Threshold = 8'h80;
        TrigSlope = 1'b1;
        Sample    = '0;

        vecs[0] = '{"riseBasic",    1'b1,  6, 8'h10, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h90}, 1, 0, 1'b1, 5'd6, 5'd2};
        vecs[1] = '{"prefillCross", 1'b1,  0, 8'h00, {8'h0, 8'h90, 8'h10, 8'h10, 8'h90, 8'h10}, 5, 0, 1'b1, 5'd4, 5'd0};
        vecs[2] = '{"addrWrap",     1'b1, 40, 8'h10, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h90}, 1, 0, 1'b1, 5'd8, 5'd4};
        vecs[3] = '{"riseEqual",    1'b1,  5, 8'h7F, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h80}, 1, 0, 1'b1, 5'd5, 5'd1};
        vecs[4] = '{"fallEqual",    1'b0,  5, 8'h81, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h80}, 1, 0, 1'b1, 5'd5, 5'd1};
        vecs[5] = '{"fallNoTrig",   1'b0,  5, 8'h80, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h7F}, 1, 0, 1'b0, 5'd0, 5'd0};
        vecs[6] = '{"stalledValid", 1'b1,  6, 8'h10, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h90}, 1, 2, 1'b1, 5'd6, 5'd2};

        doReset();
        @(negedge Clock);
        checkOutput("resetOutputs", {WrEn, WrAddr, WrData, TrigAddr, StartAddr, Busy, CaptureDone}, 32'd0);

        for (int i = 0; i < 7; i++) runVector(vecs[i]);

        // Abort in WAIT_TRIG; ReadDone outside DONE must be ignored first
        doReset();
        TrigSlope = 1'b1;
        armCapture();
        for (int i = 0; i < PRE + 1; i++) applyStimulus(8'h10, 1'b1, 0);
        SampleValid = 1'b0;
        ReadDone    = 1'b1;
        tick();
        ReadDone = 1'b0;
        @(negedge Clock);
        checkOutput("readDoneIgnored", {30'd0, Busy, CaptureDone}, 32'd2);
        TriggerArmed = 1'b0;
        SampleValid  = 1'b1;
        Sample       = 8'h90;
        tick();
        SampleValid = 1'b0;
        @(negedge Clock);
        checkOutput("abortWait", {30'd0, WrEn, Busy}, 32'd0);
        tick();
        @(negedge Clock);
        checkOutput("abortStaysIdle", {30'd0, Busy, CaptureDone}, 32'd0);

        // Dropping the arm level during POST does not stop the capture
        doReset();
        armCapture();
        for (int i = 0; i < 6; i++) applyStimulus(8'h10, 1'b1, 0);
        applyStimulus(8'h90, 1'b1, 0);
        @(negedge Clock);
        checkOutput("armDropTrigAddr", 32'(TrigAddr), 32'd6);
        runPost(8'h40, 1'b1);

        // Reset in the middle of POST clears every output
        doReset();
        armCapture();
        for (int i = 0; i < 6; i++) applyStimulus(8'h10, 1'b1, 0);
        applyStimulus(8'h90, 1'b1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h30, 1'b1, 0);
        SampleValid  = 1'b0;
        TriggerArmed = 1'b0;
        Reset        = 1'b1;
        tick();
        @(negedge Clock);
        checkOutput("resetMidPost", {WrEn, WrAddr, WrData, TrigAddr, StartAddr, Busy, CaptureDone}, 32'd0);
        Reset = 1'b0;
        tick();
        @(negedge Clock);
        checkOutput("idleAfterReset", {30'd0, Busy, CaptureDone}, 32'd0);

`ifdef TRIG_FORCE_EN
        // Force in PREFILL is ignored; force on the third WAIT_TRIG sample triggers
        doReset();
        armCapture();
        forceTrig = 1'b1;
        applyStimulus(8'h10, 1'b1, 0);
        forceTrig = 1'b0;
        for (int i = 0; i < PRE + 1; i++) applyStimulus(8'h10, 1'b1, 0);
        forceTrig = 1'b1;
        applyStimulus(8'h10, 1'b1, 0);
        forceTrig = 1'b0;
        @(negedge Clock);
        checkOutput("forceTrigAddr", 32'(TrigAddr), 32'd6);
        checkOutput("forceStartAddr", 32'(StartAddr), 32'd2);
        runPost(8'h60, 1'b0);
`endif

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
